tl_burst_tracker: RTL

- Sits on a TileLink-UL port directly upstream of the per-port assertion monitors. Watches A (request) and D (response) channel handshakes.
- Tracks multi-beat burst position (first/last/beat index) per channel, and the count of outstanding requests against a configured limit.
- Publishes those as registered status, plus sticky protocol-error flags, for the monitors to compare and fire on.

---
 rtl/tl_burst_tracker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tl_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tl_burst_tracker
// Description : TileLink-UL burst and outstanding-request tracker. It observes
//               A and D channel handshakes, reports the burst position of
//               each channel (first/last/beat index), counts outstanding
//               requests against MAX_INFLIGHT, and raises sticky
//               protocol-error flags for the downstream assertion monitors.
// Ports       : clock, reset_n          - clock, async active-low reset
//               a_valid/a_ready/a_opcode/a_size - A channel observation
//               d_valid/d_ready/d_opcode/d_size - D channel observation
//               a_first/a_last/a_beat   - A burst position
//               d_first/d_last/d_beat   - D burst position
//               inflight/inflight_limit - outstanding count and its limit
//               err_*                   - sticky protocol-error flags
// Revision    : 1.0 - initial release
// ============================================================================
module tl_burst_tracker #(
    parameter int BEAT_BYTES   = 4,
    parameter int MAX_LGSIZE   = 6,
    parameter int SIZE_W       = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3,
    parameter int BEAT_W       = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [SIZE_W-1:0] a_size,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [SIZE_W-1:0] d_size,
    output logic              a_first,
    output logic              a_last,
    output logic [BEAT_W-1:0] a_beat,
    output logic              d_first,
    output logic              d_last,
    output logic [BEAT_W-1:0] d_beat,
    output logic [CNT_W-1:0]  inflight,
    output logic [CNT_W-1:0]  inflight_limit,
    output logic              err_a_change,
    output logic              err_d_change,
    output logic              err_size,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              err_any
);

    localparam logic [SIZE_W-1:0] c_LG_BEAT  = SIZE_W'($clog2(BEAT_BYTES));
    localparam logic [SIZE_W-1:0] c_MAX_LG   = SIZE_W'(MAX_LGSIZE);
    localparam logic [CNT_W-1:0]  c_MAX_INFL = CNT_W'(MAX_INFLIGHT);
    localparam logic [BEAT_W:0]   c_REM_ONE  = (BEAT_W+1)'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    // Beats in a message; oversize requests are clamped so the count stays
    // bounded even though the request itself is flagged as illegal.
    function automatic logic [BEAT_W:0] f_beats(input logic              has_data,
                                                 input logic [SIZE_W-1:0] size);
        logic [SIZE_W-1:0] eff;
        eff = (size > c_MAX_LG) ? c_MAX_LG : size;
        if (has_data && (eff > c_LG_BEAT))
            f_beats = c_REM_ONE << (eff - c_LG_BEAT);
        else
            f_beats = c_REM_ONE;
    endfunction

    // Index 0 is the A channel, index 1 the D channel.
    logic [1:0]              w_fire;
    logic [1:0]              w_has_data;
    logic [1:0][2:0]         w_op;
    logic [1:0][SIZE_W-1:0]  w_size;
    logic [1:0]              w_first;
    logic [1:0]              w_last;
    logic [1:0][BEAT_W-1:0]  w_beat;
    logic [1:0]              w_chg;
    logic [1:0]              w_size_bad;

    assign w_fire[0]     = a_valid & a_ready;
    assign w_fire[1]     = d_valid & d_ready;
    assign w_has_data[0] = (a_opcode <= 3'd3);
    assign w_has_data[1] = (d_opcode == 3'd1);
    assign w_op[0]       = a_opcode;
    assign w_op[1]       = d_opcode;
    assign w_size[0]     = a_size;
    assign w_size[1]     = d_size;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic [0:0]        r_state;
            logic [0:0]        w_state_nxt;
            logic [BEAT_W:0]   r_rem;
            logic [BEAT_W:0]   w_rem_nxt;
            logic [BEAT_W-1:0] r_beat;
            logic [BEAT_W-1:0] w_beat_nxt;
            logic [2:0]        r_op;
            logic [2:0]        w_op_nxt;
            logic [SIZE_W-1:0] r_size;
            logic [SIZE_W-1:0] w_size_nxt;
            logic [BEAT_W:0]   w_in_beats;

            assign w_in_beats = f_beats(w_has_data[g], w_size[g]);

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= c_IDLE;
                    r_rem   <= '0;
                    r_beat  <= '0;
                    r_op    <= '0;
                    r_size  <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_rem   <= w_rem_nxt;
                    r_beat  <= w_beat_nxt;
                    r_op    <= w_op_nxt;
                    r_size  <= w_size_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_rem_nxt   = r_rem;
                w_beat_nxt  = r_beat;
                w_op_nxt    = r_op;
                w_size_nxt  = r_size;
                if (w_fire[g]) begin
                    if (r_state == c_IDLE) begin
                        if (w_in_beats != c_REM_ONE) begin
                            w_state_nxt = c_BURST;
                            w_rem_nxt   = w_in_beats - c_REM_ONE;
                            w_beat_nxt  = BEAT_W'(1);
                            w_op_nxt    = w_op[g];
                            w_size_nxt  = w_size[g];
                        end
                    end else begin
                        // Latched fields keep governing the count even if a
                        // mid-burst beat presents different ones.
                        w_rem_nxt  = r_rem - c_REM_ONE;
                        w_beat_nxt = r_beat + BEAT_W'(1);
                        if (r_rem == c_REM_ONE) begin
                            w_state_nxt = c_IDLE;
                            w_beat_nxt  = '0;
                        end
                    end
                end
            end

            assign w_first[g]    = (r_state == c_IDLE);
            assign w_beat[g]     = r_beat;
            assign w_last[g]     = (r_state == c_IDLE) ? (w_in_beats == c_REM_ONE)
                                                       : (r_rem == c_REM_ONE);
            assign w_chg[g]      = w_fire[g] & (r_state == c_BURST) &
                                   ((w_op[g] != r_op) | (w_size[g] != r_size));
            assign w_size_bad[g] = w_fire[g] & (r_state == c_IDLE) &
                                   (w_size[g] > c_MAX_LG);
        end
    endgenerate

    // Outstanding-request counter and sticky error flags.
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] r_inflight;
    logic             r_err_a_change;
    logic             r_err_d_change;
    logic             r_err_size;
    logic             r_err_overflow;
    logic             r_err_underflow;

    assign w_inc = w_fire[0] & w_last[0];
    assign w_dec = w_fire[1] & w_last[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight      <= '0;
            r_err_a_change  <= 1'b0;
            r_err_d_change  <= 1'b0;
            r_err_size      <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            // Simultaneous request and response completion cancel out and
            // are deliberately exempt from the over/underflow checks.
            if (w_inc && !w_dec) begin
                if (r_inflight == c_MAX_INFL)
                    r_err_overflow <= 1'b1;
                else
                    r_inflight <= r_inflight + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
                if (r_inflight == '0)
                    r_err_underflow <= 1'b1;
                else
                    r_inflight <= r_inflight - CNT_W'(1);
            end
            r_err_a_change <= r_err_a_change | w_chg[0];
            r_err_d_change <= r_err_d_change | w_chg[1];
            r_err_size     <= r_err_size | (|w_size_bad);
        end
    end

    assign a_first        = w_first[0];
    assign a_last         = w_last[0];
    assign a_beat         = w_beat[0];
    assign d_first        = w_first[1];
    assign d_last         = w_last[1];
    assign d_beat         = w_beat[1];
    assign inflight       = r_inflight;
    assign inflight_limit = c_MAX_INFL;
    assign err_a_change   = r_err_a_change;
    assign err_d_change   = r_err_d_change;
    assign err_size       = r_err_size;
    assign err_overflow   = r_err_overflow;
    assign err_underflow  = r_err_underflow;
    assign err_any        = r_err_a_change | r_err_d_change | r_err_size |
                            r_err_overflow | r_err_underflow;

endmodule
`default_nettype wire
